// File: rtl/nibble_collect_fifo.sv
// nibble_collect_fifo
// Assembles a serial bit stream into 4-bit nibbles (first bit lands in the
// MSB) and buffers complete nibbles in a circular FIFO of DEPTH entries.
// A nibble that completes while the buffer is full and nothing drains on the
// same edge is dropped, and the sticky overflow flag records it.
//
// Handshake: out_valid is high whenever the FIFO holds at least one nibble
// and out_data then shows the head entry. An entry is consumed on a rising
// edge where out_valid and out_ready are both high. out_ready while
// out_valid is low has no effect. out_valid/out_data/level come only from
// registers, so the consumer may make out_ready depend on them freely.
module nibble_collect_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     bit_in,
  input  logic                     bit_valid,
  input  logic                     flush,
  output logic [3:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [1:0]               bit_cnt,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  // Assembly state
  logic [2:0]    sh_q, sh_d;
  logic [1:0]    cnt_q, cnt_d;

  // FIFO state
  logic [3:0]    mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;

  // Per-edge events
  logic          accept;
  logic          complete;
  logic [3:0]    nibble;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  // Decode what happens on the coming edge from registered state and inputs.
  always_comb begin
    accept   = bit_valid & ~flush;
    complete = accept & (cnt_q == 2'd3);
    nibble   = {sh_q, bit_in};
    full     = (level_q == FULL_LEVEL);
    pop      = (level_q != '0) & out_ready;
    // At full a same-edge pop frees the slot the new nibble needs.
    push     = complete & (~full | pop);
    drop     = complete & full & ~pop;
  end

  // Next-state for the shift register, counters, pointers and overflow flag.
  always_comb begin
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    ovf_d   = ovf_q;

    if (flush) begin
      sh_d  = 3'b000;
      cnt_d = 2'd0;
    end else if (bit_valid) begin
      sh_d  = {sh_q[1:0], bit_in};
      cnt_d = cnt_q + 2'd1;
    end

    if (push) wptr_d = wptr_q + PW'(1);
    if (pop)  rptr_d = rptr_q + PW'(1);

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (drop) ovf_d = 1'b1;
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q    <= 3'b000;
      cnt_q   <= 2'd0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  // Nibble storage; cleared on reset so the array never holds X.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 4'h0;
    end else if (push) begin
      mem_q[wptr_q] <= nibble;
    end
  end

  // Outputs are pure functions of registered state; data masked when empty.
  always_comb begin
    out_valid = (level_q != '0);
    out_data  = out_valid ? mem_q[rptr_q] : 4'h0;
    level     = level_q;
    bit_cnt   = cnt_q;
    overflow  = ovf_q;
  end

endmodule

// File: tb/tb_nibble_collect_fifo.sv
// Bench for nibble_collect_fifo (DEPTH=4): a table of per-edge vectors with
// hand-computed outputs, then hand-written reset, overflow, full-with-pop
// sequences that drain through an expected-value queue.
module tb_nibble_collect_fifo;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic          bit_in;
  logic          bit_valid;
  logic          flush;
  logic [3:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] level;
  logic [1:0]    bit_cnt;
  logic          overflow;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] exp_q[$];

  typedef struct {
    logic          bv;
    logic          bi;
    logic          fl;
    logic          rdy;
    logic [3:0]    e_data;
    logic          e_valid;
    logic [LW-1:0] e_level;
    logic [1:0]    e_cnt;
    logic          e_ovf;
  } vec_t;

  vec_t vecs[$];

  nibble_collect_fifo #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .flush     (flush),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .bit_cnt   (bit_cnt),
    .overflow  (overflow)
  );

  // Clock and initial reset level
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  // Drive inputs at the falling edge, let one rising edge happen, return at
  // the next falling edge where outputs are sampled.
  task automatic tick(input logic bv, input logic bi, input logic fl, input logic rdy);
    bit_valid = bv;
    bit_in    = bi;
    flush     = fl;
    out_ready = rdy;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++)
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    rst = 1'b0;
  endtask

  task automatic send_nibble(input logic [3:0] n, input logic rdy);
    for (int i = 3; i >= 0; i--) tick(1'b1, n[i], 1'b0, rdy);
  endtask

  task automatic check_outputs(input string tag, input int d, input int v,
                               input int l, input int c, input int o);
    check({tag, ".out_data"},  int'(out_data),  d);
    check({tag, ".out_valid"}, int'(out_valid), v);
    check({tag, ".level"},     int'(level),     l);
    check({tag, ".bit_cnt"},   int'(bit_cnt),   c);
    check({tag, ".overflow"},  int'(overflow),  o);
  endtask

  // Scoreboard drain: pop with out_ready high, comparing each head against
  // the expected queue, bounded by a cycle budget.
  task automatic drain(input string tag);
    int budget;
    budget = 4 * DEPTH;
    while (out_valid && budget > 0) begin
      if (exp_q.size() == 0) begin
        check({tag, ".unexpected_entry"}, int'(out_data), -1);
      end else begin
        check({tag, ".drain_data"}, int'(out_data), int'(exp_q.pop_front()));
      end
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      budget--;
    end
    check({tag, ".drain_budget_ok"}, int'(budget > 0), 1);
    check({tag, ".entries_left"}, exp_q.size(), 0);
    check({tag, ".out_valid_after"}, int'(out_valid), 0);
    check({tag, ".level_after"}, int'(level), 0);
    exp_q.delete();
  endtask

  function automatic void add(input logic bv, input logic bi, input logic fl,
                              input logic rdy, input logic [3:0] d, input logic v,
                              input logic [LW-1:0] l, input logic [1:0] c,
                              input logic o);
    vec_t x;
    x.bv = bv; x.bi = bi; x.fl = fl; x.rdy = rdy;
    x.e_data = d; x.e_valid = v; x.e_level = l; x.e_cnt = c; x.e_ovf = o;
    vecs.push_back(x);
  endfunction

  initial begin
    //   bv bi fl rdy  data v lvl cnt ovf   (outputs after the edge)
    // bits 1,0,1,1 with no consumer -> 4'b1011 after the 4th edge
    add(1, 1, 0, 0, 4'h0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 4'h0, 0, 0, 2, 0);
    add(1, 1, 0, 0, 4'h0, 0, 0, 3, 0);
    add(1, 1, 0, 0, 4'hB, 1, 1, 0, 0);
    add(0, 0, 0, 1, 4'h0, 0, 0, 0, 0);
    // 1,1 then flush together with a bit, then 0,1,1,0 -> 4'b0110
    add(1, 1, 0, 0, 4'h0, 0, 0, 1, 0);
    add(1, 1, 0, 0, 4'h0, 0, 0, 2, 0);
    add(1, 1, 1, 0, 4'h0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 4'h0, 0, 0, 1, 0);
    add(1, 1, 0, 0, 4'h0, 0, 0, 2, 0);
    add(1, 1, 0, 0, 4'h0, 0, 0, 3, 0);
    add(1, 0, 0, 0, 4'h6, 1, 1, 0, 0);
    add(0, 0, 0, 1, 4'h0, 0, 0, 0, 0);
    // flush with a would-be 4th bit completes nothing
    add(1, 1, 0, 0, 4'h0, 0, 0, 1, 0);
    add(1, 1, 0, 0, 4'h0, 0, 0, 2, 0);
    add(1, 1, 0, 0, 4'h0, 0, 0, 3, 0);
    add(1, 1, 1, 0, 4'h0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 4'h0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 4'h0, 0, 0, 2, 0);
    add(1, 0, 0, 0, 4'h0, 0, 0, 3, 0);
    add(1, 1, 0, 0, 4'h1, 1, 1, 0, 0);
    add(0, 0, 0, 1, 4'h0, 0, 0, 0, 0);
    // eight 1s with out_ready held high -> 0xF, 0xF
    add(1, 1, 0, 1, 4'h0, 0, 0, 1, 0);
    add(1, 1, 0, 1, 4'h0, 0, 0, 2, 0);
    add(1, 1, 0, 1, 4'h0, 0, 0, 3, 0);
    add(1, 1, 0, 1, 4'hF, 1, 1, 0, 0);
    add(1, 1, 0, 1, 4'h0, 0, 0, 1, 0);
    add(1, 1, 0, 1, 4'h0, 0, 0, 2, 0);
    add(1, 1, 0, 1, 4'h0, 0, 0, 3, 0);
    add(1, 1, 0, 1, 4'hF, 1, 1, 0, 0);
    // bit_valid every other cycle, eight 0s -> 0x0, 0x0
    add(1, 0, 0, 1, 4'h0, 0, 0, 1, 0);
    add(0, 1, 0, 1, 4'h0, 0, 0, 1, 0);
    add(1, 0, 0, 1, 4'h0, 0, 0, 2, 0);
    add(0, 1, 0, 1, 4'h0, 0, 0, 2, 0);
    add(1, 0, 0, 1, 4'h0, 0, 0, 3, 0);
    add(0, 1, 0, 1, 4'h0, 0, 0, 3, 0);
    add(1, 0, 0, 1, 4'h0, 1, 1, 0, 0);
    add(0, 1, 0, 1, 4'h0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 4'h0, 0, 0, 1, 0);
    add(0, 1, 0, 1, 4'h0, 0, 0, 1, 0);
    add(1, 0, 0, 1, 4'h0, 0, 0, 2, 0);
    add(0, 1, 0, 1, 4'h0, 0, 0, 2, 0);
    add(1, 0, 0, 1, 4'h0, 0, 0, 3, 0);
    add(0, 1, 0, 1, 4'h0, 0, 0, 3, 0);
    add(1, 0, 0, 1, 4'h0, 1, 1, 0, 0);
    add(0, 0, 0, 1, 4'h0, 0, 0, 0, 0);

    rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    @(negedge clk);

    // 1. reset with random inputs
    do_reset(2);
    check_outputs("reset", 0, 0, 0, 0, 0);

    // table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      tick(vecs[i].bv, vecs[i].bi, vecs[i].fl, vecs[i].rdy);
      check_outputs($sformatf("vec%0d", i), int'(vecs[i].e_data), int'(vecs[i].e_valid),
                    int'(vecs[i].e_level), int'(vecs[i].e_cnt), int'(vecs[i].e_ovf));
    end

    // 1b. reset in the middle of a nibble with two entries stored
    do_reset(1);
    send_nibble(4'h3, 1'b0);
    send_nibble(4'h5, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    check_outputs("pre_mid_reset", 3, 1, 2, 2, 0);
    do_reset(1);
    check_outputs("mid_reset", 0, 0, 0, 0, 0);

    // 3. five nibbles into a 4-deep FIFO: the fifth is dropped
    for (int n = 1; n <= 4; n++) begin
      send_nibble(4'(n), 1'b0);
      exp_q.push_back(4'(n));
    end
    check("ovf.level_at_16", int'(level), 4);
    check("ovf.flag_at_16", int'(overflow), 0);
    send_nibble(4'h5, 1'b0);
    check("ovf.level_at_20", int'(level), 4);
    check("ovf.flag_at_20", int'(overflow), 1);
    drain("ovf");
    check("ovf.sticky", int'(overflow), 1);

    // 4. full FIFO: last bit of 0xA coincides with a pop
    do_reset(1);
    for (int n = 1; n <= 4; n++) begin
      send_nibble(4'(n), 1'b0);
      if (n > 1) exp_q.push_back(4'(n));
    end
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    check("fullpop.level_before", int'(level), 4);
    check("fullpop.head_before", int'(out_data), 1);
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(4'hA);
    check("fullpop.level", int'(level), 4);
    check("fullpop.overflow", int'(overflow), 0);
    check("fullpop.bit_cnt", int'(bit_cnt), 0);
    drain("fullpop");
    check("fullpop.overflow_end", int'(overflow), 0);

    // wrap-around ordering: interleave pushes and pops past the pointer wrap
    do_reset(1);
    for (int n = 0; n < 6; n++) begin
      send_nibble(4'(4'h9 + n), 1'b0);
      exp_q.push_back(4'(4'h9 + n));
      if (n % 2 == 1) begin
        check($sformatf("wrap.pop%0d", n), int'(out_data), int'(exp_q.pop_front()));
        tick(1'b0, 1'b0, 1'b0, 1'b1);
      end
    end
    drain("wrap");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/nibble_collect_fifo.md
# nibble_collect_fifo

Downstream stage of the serial-in shift register in the FIFO area. It consumes the same serial bit stream (`d`), assembles every four accepted bits into a nibble, and buffers complete nibbles in a small circular FIFO. The FIFO drains through a valid/ready interface. It gives the serial front end a lossless, flow-controlled parallel output and flags any nibble dropped because the buffer was full.

## Interface
Parameters:
- `DEPTH`, default 4: number of nibble entries. Must be a power of two, 2 or more.

Ports:
- `clk`, in, 1: clock. All state updates on the rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `bit_in`, in, 1: serial data bit.
- `bit_valid`, in, 1: `bit_in` is accepted on this edge.
- `flush`, in, 1: discards the partially assembled nibble. FIFO contents are untouched.
- `out_data`, out, 4: head nibble. The first-received bit is in `out_data[3]`. Reads 0 when `out_valid`=0.
- `out_valid`, out, 1: FIFO is non-empty.
- `out_ready`, in, 1: consumer accepts the head on this edge when `out_valid`=1.
- `level`, out, $clog2(DEPTH)+1: number of stored nibbles, 0..DEPTH.
- `bit_cnt`, out, 2: bits held in the partial nibble, 0..3.
- `overflow`, out, 1: sticky. Set when a completed nibble is dropped. Cleared only by `rst`.

## Operation
Assembly:
- Internal shift register `sh[2:0]`.
- On `bit_valid`=1 and `flush`=0: `sh` <= {`sh[1:0]`, `bit_in`}, and `bit_cnt` increments mod 4.
- When `bit_cnt`=3 and the bit is accepted, the nibble {`sh[2:0]`, `bit_in`} is complete. `bit_cnt` wraps to 0.
- `flush`=1 forces `sh`=0 and `bit_cnt`=0. If `flush` and `bit_valid` are high together, flush wins and the bit is discarded.

FIFO:
- Storage `mem[DEPTH]`, with write and read pointers that wrap modulo DEPTH. `level` is registered.
- Pop: `out_valid` and `out_ready` both high. The read pointer advances.
- Push: a nibble completes and either `level` < DEPTH or a pop happens on the same edge.
- Full, a nibble completes, and no pop: the nibble is dropped, `overflow` <= 1, and storage is unchanged.
- Simultaneous push and pop at any level: `level` is unchanged. At full this is legal and no overflow occurs.
- No bypass path. An empty FIFO never presents a nibble in the same cycle it completes.
- `out_ready` while `out_valid`=0 has no effect.
- `out_data`, `out_valid` and `level` depend only on registered state. There is no combinational path from `out_ready` or `bit_in` to any output.
- Ordering is strict FIFO across pointer wrap-around.

## Timing
- Reset values: `out_data`=0, `out_valid`=0, `level`=0, `bit_cnt`=0, `overflow`=0. `sh`=0 and both pointers are 0.
- Reset mid-operation discards the partial nibble and all stored nibbles on that edge.
- Latency: the 4th bit accepted at edge N gives `out_valid`=1 with the nibble on `out_data` after edge N, provided the FIFO was empty.
- Pop at edge M: the next entry, or `out_valid`=0 if the FIFO is now empty, is presented after edge M.
- Sustained throughput: one nibble per 4 accepted bits, with no bubbles when `out_ready` is held high.
- `overflow` rises after the edge that drops the nibble.

## Test plan
1. Assert `rst` for 2 cycles with random inputs -> all outputs 0. Repeat `rst` mid-nibble (`bit_cnt`=2, `level`=2) -> `bit_cnt`=0, `level`=0, `out_valid`=0 next cycle.
2. Bits 1,0,1,1 on consecutive edges, `out_ready`=0 -> after the 4th edge: `out_valid`=1, `out_data`=4'b1011, `level`=1, `bit_cnt`=0.
3. DEPTH=4, `out_ready`=0, send 5 nibbles 0x1,0x2,0x3,0x4,0x5 -> `level`=4 and `overflow`=1 after the 20th bit. Then drain with `out_ready`=1 -> reads 0x1,0x2,0x3,0x4, then `out_valid`=0.
4. FIFO full, 4th bit of 0xA lands on the same edge as a pop -> `level` stays 4, `overflow` stays 0, 0xA is read last.
5. Two bits (1,1) then `flush`, then bits 0,1,1,0 -> exactly one nibble, 4'b0110. Also `flush` concurrent with `bit_valid` -> that bit is ignored.
6. `bit_in`=1 for 8 consecutive edges, `out_ready`=1, then `bit_valid` toggled every other cycle over 8 more bits of 0 -> nibbles 0xF, 0xF, 0x0, 0x0 in order, each `out_valid` asserted the cycle after its 4th bit.
